alu_pipe: RTL and testbench

- Parametrised, registered N-bit ALU. Successor to the bit-sliced combinational ALU.
- Adds MIPS-style ops (SUB, SLT, NOR), status flags, valid/ready handshake on input and output, and an optional iterative unsigned multiplier.
- Sits in the EX stage of the pipelined datapath. Single-cycle ops give one result per cycle; multiply stalls the producer through InReady.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_mul_iter.sv | 53 +++++
 rtl/alu_pipe.sv | 152 +++++++++++++++
 tb/tb_alu_pipe.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for alu_pipe: operation select codes and FSM state encoding.
// The MUL state exists only when ALU_PIPE_MULT_EN is defined.
package alu_pkg;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_MULU = 3'b011;
    localparam logic [2:0] ALU_NOR  = 3'b100;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

`ifdef ALU_PIPE_MULT_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_MUL  = 2'd2
    } alu_state_e;
`else
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } alu_state_e;
`endif

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier: one multiplier bit per cycle after start.
// done is high during the last iteration; product/carry then show the final sum.
module alu_mul_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic             carry
);

    logic [2*WIDTH-1:0] a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [2*WIDTH-1:0] acc_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic               busy_reg;

    assign acc_next = acc_reg + (b_reg[0] ? a_reg : '0);
    assign done     = busy_reg && (cnt_reg == CNT_W'(WIDTH - 1));
    assign product  = acc_next[WIDTH-1:0];
    assign carry    = |acc_next[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            acc_reg  <= '0;
            cnt_reg  <= '0;
            busy_reg <= 1'b0;
        end else if (start) begin
            a_reg    <= {{WIDTH{1'b0}}, a};
            b_reg    <= b;
            acc_reg  <= '0;
            cnt_reg  <= '0;
            busy_reg <= 1'b1;
        end else if (busy_reg) begin
            acc_reg <= acc_next;
            a_reg   <= a_reg << 1;
            b_reg   <= b_reg >> 1;
            cnt_reg <= cnt_reg + CNT_W'(1);
            if (done) begin
                busy_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Registered N-bit ALU with valid/ready handshakes and status flags.
// Define ALU_PIPE_MULT_EN to include the iterative MULU path (alu_mul_iter).
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             InValid,
    output logic             InReady,
    input  logic [2:0]       Sel,
    input  logic [WIDTH-1:0] DataA,
    input  logic [WIDTH-1:0] DataB,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] DataOut,
    output logic             Cout,
    output logic             Zero,
    output logic             Overflow
);

    alu_state_e       state_reg, state_next;
    logic [WIDTH-1:0] data_reg;
    logic             valid_reg, cout_reg, zero_reg, ovf_reg;

    logic [WIDTH:0]   add_sum, sub_sum;
    logic             add_ovf, sub_ovf;
    logic [WIDTH-1:0] res;
    logic             res_cout, res_ovf;
    logic             accept, is_mul, mul_done;
    logic [WIDTH-1:0] mul_product;
    logic             mul_carry;

    assign add_sum = {1'b0, DataA} + {1'b0, DataB};
    assign sub_sum = {1'b0, DataA} + {1'b0, ~DataB} + {{WIDTH{1'b0}}, 1'b1};
    assign add_ovf = (DataA[WIDTH-1] == DataB[WIDTH-1]) && (add_sum[WIDTH-1] != DataA[WIDTH-1]);
    assign sub_ovf = (DataA[WIDTH-1] != DataB[WIDTH-1]) && (sub_sum[WIDTH-1] != DataA[WIDTH-1]);

    // Single-cycle result; MULU and the reserved code fall through to zeros.
    always_comb begin
        res      = '0;
        res_cout = 1'b0;
        res_ovf  = 1'b0;
        case (Sel)
            ALU_AND: res = DataA & DataB;
            ALU_OR:  res = DataA | DataB;
            ALU_NOR: res = ~(DataA | DataB);
            ALU_ADD: begin
                res      = add_sum[WIDTH-1:0];
                res_cout = add_sum[WIDTH];
                res_ovf  = add_ovf;
            end
            ALU_SUB: begin
                res      = sub_sum[WIDTH-1:0];
                res_cout = sub_sum[WIDTH];
                res_ovf  = sub_ovf;
            end
            ALU_SLT: res = {{(WIDTH-1){1'b0}}, sub_sum[WIDTH-1] ^ sub_ovf};
            default: res = '0;
        endcase
    end

    always_comb begin
        InReady = 1'b0;
        if (rst_n) begin
            case (state_reg)
                ST_IDLE: InReady = 1'b1;
                ST_HOLD: InReady = OutReady;
                default: InReady = 1'b0;
            endcase
        end
    end

    assign accept = InValid && InReady;

`ifdef ALU_PIPE_MULT_EN
    assign is_mul = (Sel == ALU_MULU);

    alu_mul_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept && is_mul),
        .a       (DataA),
        .b       (DataB),
        .done    (mul_done),
        .product (mul_product),
        .carry   (mul_carry)
    );
`else
    logic [CNT_W-1:0] cnt_unused;
    assign cnt_unused  = '0;
    assign is_mul      = 1'b0;
    assign mul_done    = 1'b0;
    assign mul_product = '0;
    assign mul_carry   = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        if (accept) begin
            state_next = ST_HOLD;
`ifdef ALU_PIPE_MULT_EN
            if (is_mul) state_next = ST_MUL;
`endif
        end else if (state_reg == ST_HOLD && OutReady) begin
            state_next = ST_IDLE;
        end else if (mul_done) begin
            state_next = ST_HOLD;
        end
    end

    // A MULU accepted from HOLD takes the third branch, retiring the old result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            data_reg  <= '0;
            valid_reg <= 1'b0;
            cout_reg  <= 1'b0;
            zero_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept && !is_mul) begin
                data_reg  <= res;
                zero_reg  <= (res == '0);
                cout_reg  <= res_cout;
                ovf_reg   <= res_ovf;
                valid_reg <= 1'b1;
            end else if (mul_done) begin
                data_reg  <= mul_product;
                zero_reg  <= (mul_product == '0);
                cout_reg  <= mul_carry;
                ovf_reg   <= 1'b0;
                valid_reg <= 1'b1;
            end else if (state_reg == ST_HOLD && OutReady) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign OutValid = valid_reg;
    assign DataOut  = data_reg;
    assign Cout     = cout_reg;
    assign Zero     = zero_reg;
    assign Overflow = ovf_reg;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe at WIDTH=8: vector table, scoreboard queue,
// plus hand sequences for stall, multiply latency and reset-abandon.
module tb_alu_pipe;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n, InValid, OutReady;
    logic [2:0]   Sel;
    logic [W-1:0] DataA, DataB;
    logic         InReady, OutValid, Cout, Zero, Overflow;
    logic [W-1:0] DataOut;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .InValid(InValid), .InReady(InReady),
        .Sel(Sel), .DataA(DataA), .DataB(DataB), .OutValid(OutValid),
        .OutReady(OutReady), .DataOut(DataOut), .Cout(Cout), .Zero(Zero),
        .Overflow(Overflow)
    );

    typedef struct {
        logic [2:0] sel;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] data;
        logic       cout;
        logic       ovf;
        logic       zero;
        int         lat;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       cout;
        logic       ovf;
        logic       zero;
        int         lat;
        int         acc_cyc;
    } exp_t;

    exp_t sb[$];
    vec_t cur;
    vec_t tbl[17];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    bit   chk_lat = 1'b1;

`ifdef ALU_PIPE_MULT_EN
    localparam int MUL_LAT = 9;
`else
    localparam int MUL_LAT = 1;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] d, input logic c, input logic v, input int lat);
        vec_t r;
        r.sel = s; r.a = a; r.b = b; r.data = d; r.cout = c; r.ovf = v;
        r.zero = (d == 8'h00); r.lat = lat;
        return r;
    endfunction

    // Reference behaviour built from integer arithmetic and comparisons.
    function automatic vec_t model(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
        vec_t r;
        int si;
        logic [15:0] p;
        r.sel = s; r.a = a; r.b = b; r.data = 8'h00; r.cout = 1'b0; r.ovf = 1'b0; r.lat = 1;
        case (s)
            3'b000: r.data = a & b;
            3'b001: r.data = a | b;
            3'b100: r.data = ~(a | b);
            3'b010: begin
                r.data = a + b;
                r.cout = (int'(a) + int'(b)) > 255;
                si = int'($signed(a)) + int'($signed(b));
                r.ovf = (si > 127) || (si < -128);
            end
            3'b110: begin
                r.data = a - b;
                r.cout = (a >= b);
                si = int'($signed(a)) - int'($signed(b));
                r.ovf = (si > 127) || (si < -128);
            end
            3'b111: r.data = ($signed(a) < $signed(b)) ? 8'h01 : 8'h00;
`ifdef ALU_PIPE_MULT_EN
            3'b011: begin
                p = 16'(a) * 16'(b);
                r.data = p[7:0];
                r.cout = (p > 16'h00FF);
                r.lat = 9;
            end
`endif
            default: r.data = 8'h00;
        endcase
        r.zero = (r.data == 8'h00);
        return r;
    endfunction

    task automatic drive(input vec_t v);
        cur = v; InValid = 1'b1; Sel = v.sel; DataA = v.a; DataB = v.b;
    endtask

    // One clock: evaluate both handshakes for the coming edge, then advance.
    task automatic step(output bit accepted);
        exp_t x;
        #1;
        accepted = 1'b0;
        if (OutValid && OutReady) begin
            if (sb.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_output: got data 0x%0h, required no result", DataOut);
            end else begin
                x = sb.pop_front();
                $display("cycle %0d result data=0x%02h cout=%0b zero=%0b ovf=%0b (want 0x%02h %0b %0b %0b)",
                         cyc, DataOut, Cout, Zero, Overflow, x.data, x.cout, x.zero, x.ovf);
                chk("data", 32'(DataOut), 32'(x.data));
                chk("cout", 32'(Cout), 32'(x.cout));
                chk("ovf", 32'(Overflow), 32'(x.ovf));
                chk("zero", 32'(Zero), 32'(x.zero));
                if (x.lat > 0) chk("latency", 32'(cyc - x.acc_cyc), 32'(x.lat));
            end
        end
        if (InValid && InReady) begin
            accepted = 1'b1;
            x.data = cur.data; x.cout = cur.cout; x.ovf = cur.ovf; x.zero = cur.zero;
            x.lat = chk_lat ? cur.lat : 0; x.acc_cyc = cyc;
            sb.push_back(x);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic send(input vec_t v, output int tries);
        bit acc;
        drive(v);
        tries = 0;
        do begin
            step(acc);
            tries++;
        end while (!acc && tries < 40);
        if (!acc) chk("accept_timeout", 32'(tries), 32'(0));
        InValid = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        int n;
        InValid = 1'b0;
        n = 0;
        while (sb.size() > 0 && n < 60) begin
            step(acc);
            n++;
        end
        if (sb.size() > 0) chk("drain_timeout", 32'(sb.size()), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  tries, low, n, vcnt;
        bit  acc;
        vec_t v;

        tbl[0]  = mk(3'b000, 8'hF0, 8'h3C, 8'h30, 0, 0, 1);
        tbl[1]  = mk(3'b001, 8'hF0, 8'h0C, 8'hFC, 0, 0, 1);
        tbl[2]  = mk(3'b100, 8'hF0, 8'h0C, 8'h03, 0, 0, 1);
        tbl[3]  = mk(3'b000, 8'h0F, 8'hF0, 8'h00, 0, 0, 1);
        tbl[4]  = mk(3'b010, 8'h7F, 8'h01, 8'h80, 0, 1, 1);
        tbl[5]  = mk(3'b110, 8'h05, 8'h05, 8'h00, 1, 0, 1);
        tbl[6]  = mk(3'b111, 8'hFF, 8'h01, 8'h01, 0, 0, 1);
        tbl[7]  = mk(3'b010, 8'hFF, 8'h01, 8'h00, 1, 0, 1);
        tbl[8]  = mk(3'b110, 8'h80, 8'h01, 8'h7F, 1, 1, 1);
        tbl[9]  = mk(3'b110, 8'h01, 8'h02, 8'hFF, 0, 0, 1);
        tbl[10] = mk(3'b111, 8'h01, 8'hFF, 8'h00, 0, 0, 1);
        tbl[11] = mk(3'b111, 8'h80, 8'h7F, 8'h01, 0, 0, 1);
        tbl[12] = mk(3'b101, 8'hAA, 8'h55, 8'h00, 0, 0, 1);
`ifdef ALU_PIPE_MULT_EN
        tbl[13] = mk(3'b011, 8'h10, 8'h12, 8'h20, 1, 0, 9);
        tbl[14] = mk(3'b011, 8'h0F, 8'h0F, 8'hE1, 0, 0, 9);
        tbl[15] = mk(3'b011, 8'hFF, 8'hFF, 8'h01, 1, 0, 9);
`else
        tbl[13] = mk(3'b011, 8'h10, 8'h12, 8'h00, 0, 0, 1);
        tbl[14] = mk(3'b011, 8'h0F, 8'h0F, 8'h00, 0, 0, 1);
        tbl[15] = mk(3'b011, 8'hFF, 8'hFF, 8'h00, 0, 0, 1);
`endif
        tbl[16] = mk(3'b001, 8'h00, 8'h00, 8'h00, 0, 0, 1);

        rst_n = 1'b0; InValid = 1'b0; OutReady = 1'b1;
        Sel = 3'b000; DataA = '0; DataB = '0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(OutValid), 32'(0));
        chk("rst_data", 32'(DataOut), 32'(0));
        chk("rst_cout", 32'(Cout), 32'(0));
        chk("rst_zero", 32'(Zero), 32'(0));
        chk("rst_ovf", 32'(Overflow), 32'(0));
        chk("rst_in_ready", 32'(InReady), 32'(0));
        rst_n = 1'b1;

        // Back-to-back table stream with the consumer always ready.
        for (int i = 0; i < 17; i++) begin
            send(tbl[i], tries);
            if (i >= 1 && i <= 12) chk("in_ready_streak", 32'(tries), 32'(1));
        end
        drain();

        // Multiply: producer stalled for WIDTH cycles after the accept.
        v = mk(3'b011, 8'h10, 8'h12, 8'h00, 0, 0, MUL_LAT);
        v = model(3'b011, 8'h10, 8'h12);
        send(v, tries);
        low = 0; n = 0;
        while (!OutValid && n < 30) begin
            if (!InReady) low++;
            step(acc);
            n++;
        end
        chk("mul_in_ready_low", 32'(low), 32'(MUL_LAT - 1));
        drain();

        // Consumer stall: result and flags held, no new accept.
        OutReady = 1'b0;
        chk_lat = 1'b0;
        send(mk(3'b010, 8'h01, 8'h02, 8'h03, 0, 0, 1), tries);
        drive(mk(3'b001, 8'h11, 8'h22, 8'h33, 0, 0, 1));
        for (int k = 0; k < 3; k++) begin
            step(acc);
            chk("stall_accept", 32'(acc), 32'(0));
            chk("stall_in_ready", 32'(InReady), 32'(0));
            chk("stall_valid", 32'(OutValid), 32'(1));
            chk("stall_data", 32'(DataOut), 32'(8'h03));
        end
        OutReady = 1'b1;
        step(acc);
        chk("stall_release_accept", 32'(acc), 32'(1));
        drain();

        // Random traffic with a randomly stalling consumer.
        for (int k = 0; k < 40; k++) begin
            v = model(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
            drive(v);
            InValid = ($urandom_range(0, 3) != 0);
            OutReady = ($urandom_range(0, 3) != 0);
            step(acc);
        end
        OutReady = 1'b1;
        drain();
        chk_lat = 1'b1;

        // Reset four cycles into a multiply (or with a held result otherwise).
`ifdef ALU_PIPE_MULT_EN
        OutReady = 1'b1;
`else
        OutReady = 1'b0;
`endif
        send(model(3'b011, 8'h10, 8'h12), tries);
        repeat (4) step(acc);
        rst_n = 1'b0;
        step(acc);
        sb.delete();
        chk("midrst_valid", 32'(OutValid), 32'(0));
        chk("midrst_data", 32'(DataOut), 32'(0));
        chk("midrst_cout", 32'(Cout), 32'(0));
        chk("midrst_zero", 32'(Zero), 32'(0));
        chk("midrst_ovf", 32'(Overflow), 32'(0));
        chk("midrst_in_ready", 32'(InReady), 32'(0));
        rst_n = 1'b1;
        OutReady = 1'b1;
        vcnt = 0;
        for (int k = 0; k < 12; k++) begin
            if (OutValid) vcnt++;
            step(acc);
        end
        chk("no_stale_valid", 32'(vcnt), 32'(0));
        send(tbl[4], tries);
        chk("post_rst_accept", 32'(tries), 32'(1));
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
